// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter that shares one Montgomery multiplier among N_REQ requesters.
// Operands are captured on grant and held until the product is returned to the owner.
module mont_mul_arbiter #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_b,
    output logic [N_REQ-1:0]       o_ack,
    output logic [N_REQ-1:0]       o_valid,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_busy,
    output logic                   o_mm_start,
    output logic [WIDTH-1:0]       o_mm_a,
    output logic [WIDTH-1:0]       o_mm_b,
    input  logic [WIDTH-1:0]       i_mm_result,
    input  logic                   i_mm_finished
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   mm_a_q, mm_a_d;
    logic [WIDTH-1:0]   mm_b_q, mm_b_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k] = i_a[k*WIDTH +: WIDTH];
        assign b_arr[k] = i_b[k*WIDTH +: WIDTH];
    end

    // Search starts just after the last grant, so the previous owner is checked last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (!grant_found && i_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // NOTE: every output and next-state value gets a default before the case, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        result_d   = result_q;
        o_ack      = '0;
        o_valid    = '0;
        o_mm_start = 1'b0;
        o_busy     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    mm_a_d  = a_arr[grant_idx];
                    mm_b_d  = b_arr[grant_idx];
                    owner_d = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_mm_start     = 1'b1;
                o_ack[owner_q] = 1'b1;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_mm_finished) begin
                    result_d = i_mm_result;
                    state_d  = ST_RETURN;
                end
            end
            ST_RETURN: begin
                o_valid[owner_q] = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the wide operand/result registers are reset too, because they are visible outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= IDX_W'(N_REQ - 1);
            owner_q  <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            result_q <= result_d;
        end
    end

    assign o_mm_a   = mm_a_q;
    assign o_mm_b   = mm_b_q;
    assign o_result = result_q;

endmodule
